// File: rtl/math_pipelined_alu.sv
// Chunk-pipelined add/subtract ALU: each stage resolves one CHUNK-wide slice of the
// operands and hands the carry to the next stage, sustaining one beat per cycle.
module math_pipelined_alu #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic             op_sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK       = (WIDTH + LATENCY - 1) / LATENCY;
    localparam int CHUNK_COUNT = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int LAST        = WIDTH - (CHUNK_COUNT - 1) * CHUNK;
    localparam int PADW        = WIDTH + (CHUNK - LAST);
    localparam int LS          = CHUNK_COUNT - 1;
    // Operands are zero-padded to whole chunks, so bit WIDTH of the padded sum is the true carry
    localparam logic [PADW:0] CARRY_SEL = (PADW + 1)'(1) << WIDTH;

    logic [CHUNK_COUNT-1:0]           valid_q, valid_d;
    logic [CHUNK_COUNT-1:0]           carry_q, carry_d;
    logic [CHUNK_COUNT-1:0]           zero_q, zero_d;
    logic [CHUNK_COUNT-1:0]           sub_q, sub_d;
    logic [CHUNK_COUNT-1:0][PADW-1:0] aOp_q, aOp_d;
    logic [CHUNK_COUNT-1:0][PADW-1:0] bOp_q, bOp_d;
    logic [CHUNK_COUNT-1:0][PADW-1:0] sum_q, sum_d;
    logic                             cout_q, cout_d;
    logic                             ovf_q, ovf_d;

    logic [PADW-1:0] aIn, bIn, mask;
    logic [CHUNK:0]  part;
    logic            carryOut;
    logic            unusedBits;

    assign in_ready  = !valid_q[LS] || out_ready;
    assign out_valid = valid_q[LS];
    assign result    = sum_q[LS][WIDTH-1:0];
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q[LS];

    // Final-stage operand copies exist only for uniform indexing and are never read
    assign unusedBits = ^{aOp_q[LS], bOp_q[LS], sub_q[LS], carry_q[LS], sum_q[LS]};

    always_comb begin
        aIn     = '0;
        bIn     = '0;
        mask    = '0;
        valid_d = '0;
        carry_d = '0;
        zero_d  = '0;
        sub_d   = '0;
        aOp_d   = '0;
        bOp_d   = '0;
        sum_d   = '0;

        aIn[WIDTH-1:0]  = I1;
        bIn[WIDTH-1:0]  = op_sub ? ~I2 : I2;
        mask[WIDTH-1:0] = '1;

        // Subtraction runs as I1 + ~I2 + !cin, so the stage-0 carry-in is cin xor op_sub
        part = {1'b0, aIn[CHUNK-1:0]} + {1'b0, bIn[CHUNK-1:0]} + (CHUNK + 1)'(op_sub ^ cin);
        valid_d[0]            = in_valid;
        sub_d[0]              = op_sub;
        aOp_d[0]              = aIn;
        bOp_d[0]              = bIn;
        sum_d[0][CHUNK-1:0]   = part[CHUNK-1:0];
        carry_d[0]            = part[CHUNK];
        zero_d[0]             = (part[CHUNK-1:0] & mask[CHUNK-1:0]) == '0;

        for (int k = 1; k < CHUNK_COUNT; k++) begin
            part = {1'b0, aOp_q[k-1][k*CHUNK +: CHUNK]}
                 + {1'b0, bOp_q[k-1][k*CHUNK +: CHUNK]}
                 + (CHUNK + 1)'(carry_q[k-1]);
            valid_d[k]                  = valid_q[k-1];
            sub_d[k]                    = sub_q[k-1];
            aOp_d[k]                    = aOp_q[k-1];
            bOp_d[k]                    = bOp_q[k-1];
            sum_d[k]                    = sum_q[k-1];
            sum_d[k][k*CHUNK +: CHUNK]  = part[CHUNK-1:0];
            carry_d[k]                  = part[CHUNK];
            zero_d[k]                   = zero_q[k-1] && ((part[CHUNK-1:0] & mask[k*CHUNK +: CHUNK]) == '0);
        end

        carryOut = |({carry_d[LS], sum_d[LS]} & CARRY_SEL);
        cout_d   = sub_d[LS] ^ carryOut;
        ovf_d    = (aOp_d[LS][WIDTH-1] == bOp_d[LS][WIDTH-1])
                && (sum_d[LS][WIDTH-1] != aOp_d[LS][WIDTH-1]);
    end

    // The whole pipeline moves as one; a stalled output freezes every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            zero_q  <= '0;
            sub_q   <= '0;
            aOp_q   <= '0;
            bOp_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (in_ready) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            sub_q   <= sub_d;
            aOp_q   <= aOp_d;
            bOp_q   <= bOp_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/math_pipelined_alu.md
MATH_PIPELINED_ALU -- requirements
Module: math_pipelined_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (>=1).
REQ-002 SHALL have parameter LATENCY, default 4, meaning maximum pipeline depth in cycles (1..WIDTH).
REQ-003 SHALL derive CHUNK = ceil(WIDTH/LATENCY), CHUNK_COUNT = ceil(WIDTH/CHUNK), and LAST = WIDTH - (CHUNK_COUNT-1)*CHUNK.
REQ-004 SHALL have clk  input  1  sole clock, rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have in_valid  input  1  operand beat present.
REQ-007 SHALL have in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have I1  input  WIDTH  first operand.
REQ-009 SHALL have I2  input  WIDTH  second operand.
REQ-010 SHALL have op_sub  input  1  0 = I1+I2+cin; 1 = I1-I2-cin.
REQ-011 SHALL have cin  input  1  carry-in (add) or borrow-in (sub).
REQ-012 SHALL have out_valid  output  1  result beat present.
REQ-013 SHALL have out_ready  input  1  downstream accepts result.
REQ-014 SHALL have result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-015 SHALL have cout  output  1  unsigned carry-out (add) or borrow-out (sub).
REQ-016 SHALL have ovf  output  1  two's-complement signed overflow.
REQ-017 SHALL have zero  output  1  result == 0.

Function
REQ-018 SHALL accept a beat when in_valid && in_ready at a rising clk edge; deliver a beat when out_valid && out_ready.
REQ-019 SHALL drive in_ready = !out_valid || out_ready, combinationally; entire pipeline advances only when in_ready = 1.
REQ-020 SHALL split operands into CHUNK_COUNT chunks, chunk 0 least significant; stage k adds/subtracts chunk k only, using the registered carry/borrow from stage k-1 (stage 0 uses cin).
REQ-021 SHALL skew operands: chunk k of an accepted beat is held in delay registers for k cycles; completed lower chunks are carried forward alongside, so one beat per cycle is sustained.
REQ-022 SHALL, with no stalls, assert out_valid with the matching result exactly CHUNK_COUNT cycles after acceptance (e.g. WIDTH=8,LATENCY=4 -> 4; WIDTH=5,LATENCY=4 -> 3).
REQ-023 SHALL implement subtraction as I1 + ~I2 + !cin per chunk internally, with cout = NOT of the final carry, so cout = 1 iff I1 < I2+cin unsigned.
REQ-024 SHALL size last chunk LAST bits; cout from the MSB of the full WIDTH result, never from padding.
REQ-025 SHALL compute ovf = (sign(I1) == sign(I2 effective)) && sign(result) != sign(I1), where I2 effective is ~I2 for sub.
REQ-026 SHALL compute zero by AND-accumulating a per-chunk "chunk is zero" bit stage by stage; no full-width compare at the output.
REQ-027 SHALL carry a valid bit per stage; bubbles (no accept) propagate as valid = 0 and do not alter other beats.
REQ-028 SHALL, while out_valid && !out_ready, hold result, cout, ovf, zero, out_valid stable and freeze all stages.
REQ-029 SHALL, on simultaneous output delivery and input accept in a full pipeline, retire and accept in the same cycle with no lost or duplicated beat.
REQ-030 SHALL sample op_sub and cin with the beat; mixed add/sub beats back-to-back are legal.
REQ-031 SHALL, for LATENCY = 1, behave as a single-register full-width ALU with latency 1.

Reset
REQ-032 SHALL, on rst_n = 0, immediately clear all stage valid bits, out_valid = 0, result = 0, cout = 0, ovf = 0, zero = 0.
REQ-033 SHALL discard all in-flight beats on reset mid-operation; first beat accepted after release returns after CHUNK_COUNT cycles.
REQ-034 SHALL hold in_ready = 1 during and after reset (pipeline empty).

Verification
REQ-035 WIDTH=8,LATENCY=4: add 0xFF+0x01,cin=0 -> 4 cycles later result=0x00,cout=1,zero=1,ovf=0.
REQ-036 WIDTH=8,LATENCY=4: add 0x7F+0x01 -> result=0x80,ovf=1,cout=0; sub 0x00-0x01 -> result=0xFF,cout=1,ovf=0; sub 0x80-0x01 -> 0x7F,ovf=1.
REQ-037 Stream 16 random beats back-to-back, out_ready=1 -> one result per cycle, in order, all matching reference model.
REQ-038 Stream with out_ready toggled randomly (50%) -> no loss/duplication, outputs stable while stalled, in_ready low only when stalled.
REQ-039 WIDTH=5,LATENCY=4: 0x1F+0x01+cin=1 -> after 3 cycles result=0x01,cout=1; cross-chunk carry verified.
REQ-040 Assert rst_n=0 with 3 beats in flight -> out_valid=0 at once, those beats never appear; post-reset beat 0x10+0x20 -> 0x30 after 4 cycles.
